// File: rtl/fwd_hazard_unit_param_if.sv
`default_nettype none
// ============================================================================
// Interface : fwd_hazard_unit_param_if
// Brief     : Pipeline-side bundle for the forwarding/hazard controller.
//             The pipeline drives operand/destination info as master; the
//             controller returns stall, flush, mux selects and status.
// Revision  : 1.0 - initial release
// ============================================================================
interface fwd_hazard_unit_param_if #(
  parameter int REG_W = 5,
  parameter int NSRC  = 2,
  parameter int CNT_W = 32
);
  logic [NSRC*REG_W-1:0] iID_Rs;
  logic [NSRC-1:0]       iID_RsUsed;
  logic                  iID_UsesInID;
  logic                  iID_Redirect;
  logic [NSRC*REG_W-1:0] iEX_Rs;
  logic [NSRC-1:0]       iEX_RsUsed;
  logic [REG_W-1:0]      iEX_Rd;
  logic [REG_W-1:0]      iMEM_Rd;
  logic [REG_W-1:0]      iWB_Rd;
  logic [1:0]            iEX_WrSrc;
  logic [1:0]            iMEM_WrSrc;
  logic [1:0]            iWB_WrSrc;
  logic                  iEX_MultiCycle;
  logic                  iEX_ExtStart;
  logic                  iEX_ExtReady;
  logic                  iClrCnt;
  logic [4:0]            oStall;
  logic [3:0]            oFlush;
  logic [NSRC*3-1:0]     oFwdID;
  logic [NSRC*3-1:0]     oFwdEX;
  logic                  oExtTimeout;
  logic [CNT_W-1:0]      oStallCycles;

  modport master (
    output iID_Rs, iID_RsUsed, iID_UsesInID, iID_Redirect,
    output iEX_Rs, iEX_RsUsed, iEX_Rd, iMEM_Rd, iWB_Rd,
    output iEX_WrSrc, iMEM_WrSrc, iWB_WrSrc,
    output iEX_MultiCycle, iEX_ExtStart, iEX_ExtReady, iClrCnt,
    input  oStall, oFlush, oFwdID, oFwdEX, oExtTimeout, oStallCycles
  );

  modport slave (
    input  iID_Rs, iID_RsUsed, iID_UsesInID, iID_Redirect,
    input  iEX_Rs, iEX_RsUsed, iEX_Rd, iMEM_Rd, iWB_Rd,
    input  iEX_WrSrc, iMEM_WrSrc, iWB_WrSrc,
    input  iEX_MultiCycle, iEX_ExtStart, iEX_ExtReady, iClrCnt,
    output oStall, oFlush, oFwdID, oFwdEX, oExtTimeout, oStallCycles
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit_param
// Brief    : Forwarding and hazard control for a 5-stage RISC-V pipeline.
//            ID- and EX-stage operand forwarding for NSRC sources, load-use
//            stall, redirect flush, multi-cycle DIV stall FSM, external-unit
//            wait FSM with watchdog, and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit_param #(
  parameter int REG_W       = 5,
  parameter int NSRC        = 2,
  parameter int MC_LAT      = 6,
  parameter int EXT_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input wire logic               iCLK,
  input wire logic               iRSTn,
  fwd_hazard_unit_param_if.slave hz
);

  localparam logic [1:0] c_WR_NONE = 2'd0;
  localparam logic [1:0] c_WR_ALU  = 2'd1;
  localparam logic [1:0] c_WR_PC4  = 2'd2;
  localparam logic [1:0] c_WR_LOAD = 2'd3;

  localparam logic [2:0] c_FWD_RF  = 3'b000;
  localparam logic [2:0] c_FWD_WB  = 3'b011;
  localparam logic [1:0] c_STG_EX  = 2'b01;
  localparam logic [1:0] c_STG_MEM = 2'b10;

  localparam int c_MC_W  = (MC_LAT > 1) ? $clog2(MC_LAT + 1) : 1;
  localparam int c_EXT_W = (EXT_TIMEOUT > 2) ? $clog2(EXT_TIMEOUT) : 1;
  localparam logic [c_MC_W-1:0]  c_MC_LAST  = c_MC_W'(MC_LAT);
  localparam logic [c_EXT_W-1:0] c_EXT_LAST = c_EXT_W'(EXT_TIMEOUT - 1);

  typedef enum logic [0:0] {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mcState_t;
  typedef enum logic [0:0] {EXT_IDLE = 1'b0, EXT_WAIT = 1'b1} extState_t;

  mcState_t            r_mcState, w_mcNext;
  logic [c_MC_W-1:0]   r_mcCnt, w_mcCntNext;
  logic                w_mcStall;
  extState_t           r_extState, w_extNext;
  logic [c_EXT_W-1:0]  r_extCnt, w_extCntNext;
  logic                w_extStall;
  logic                w_extTimeout;
  logic [NSRC*3-1:0]   w_fwdId, w_fwdEx;
  logic                w_luHit;
  logic [4:0]          w_stall;
  logic [3:0]          w_flush;
  logic [CNT_W-1:0]    r_stallCycles;

  // A producer matches a consumer operand only if it really writes a nonzero register.
  function automatic logic match(input logic [REG_W-1:0] rd, input logic [1:0] wrSrc,
                                 input logic [REG_W-1:0] rs, input logic used);
    return used && (rd != '0) && (wrSrc != c_WR_NONE) && (rd == rs);
  endfunction

  // EX/MEM results are only available for ALU and PC+4; a load there is not ready yet.
  function automatic logic [2:0] nearCode(input logic [1:0] wrSrc, input logic [1:0] stage);
    logic [2:0] code;
    code = c_FWD_RF;
    if (wrSrc == c_WR_ALU)      code = {1'b0, stage};
    else if (wrSrc == c_WR_PC4) code = {1'b1, stage};
    return code;
  endfunction

  // Per-operand forwarding selects and load-use detection, nearest producer first.
  always_comb begin
    w_fwdId = '0;
    w_fwdEx = '0;
    w_luHit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (match(hz.iEX_Rd, hz.iEX_WrSrc, hz.iID_Rs[k*REG_W +: REG_W], hz.iID_RsUsed[k]))
        w_fwdId[k*3 +: 3] = nearCode(hz.iEX_WrSrc, c_STG_EX);
      else if (match(hz.iMEM_Rd, hz.iMEM_WrSrc, hz.iID_Rs[k*REG_W +: REG_W], hz.iID_RsUsed[k]))
        w_fwdId[k*3 +: 3] = nearCode(hz.iMEM_WrSrc, c_STG_MEM);
      else if (match(hz.iWB_Rd, hz.iWB_WrSrc, hz.iID_Rs[k*REG_W +: REG_W], hz.iID_RsUsed[k]))
        w_fwdId[k*3 +: 3] = c_FWD_WB;

      if (match(hz.iMEM_Rd, hz.iMEM_WrSrc, hz.iEX_Rs[k*REG_W +: REG_W], hz.iEX_RsUsed[k]))
        w_fwdEx[k*3 +: 3] = nearCode(hz.iMEM_WrSrc, c_STG_MEM);
      else if (match(hz.iWB_Rd, hz.iWB_WrSrc, hz.iEX_Rs[k*REG_W +: REG_W], hz.iEX_RsUsed[k]))
        w_fwdEx[k*3 +: 3] = c_FWD_WB;

      if ((hz.iEX_WrSrc == c_WR_LOAD) &&
          match(hz.iEX_Rd, hz.iEX_WrSrc, hz.iID_Rs[k*REG_W +: REG_W], hz.iID_RsUsed[k]))
        w_luHit = 1'b1;
      if (hz.iID_UsesInID && (hz.iMEM_WrSrc == c_WR_LOAD) &&
          match(hz.iMEM_Rd, hz.iMEM_WrSrc, hz.iID_Rs[k*REG_W +: REG_W], hz.iID_RsUsed[k]))
        w_luHit = 1'b1;
    end
  end

  // Multi-cycle and external-wait state registers.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_mcState  <= MC_IDLE;
      r_mcCnt    <= '0;
      r_extState <= EXT_IDLE;
      r_extCnt   <= '0;
    end else begin
      r_mcState  <= w_mcNext;
      r_mcCnt    <= w_mcCntNext;
      r_extState <= w_extNext;
      r_extCnt   <= w_extCntNext;
    end
  end

  // DIV/REM hold: the entry cycle plus MC_LAT-1 busy cycles stall, then one free cycle.
  always_comb begin
    w_mcNext    = r_mcState;
    w_mcCntNext = r_mcCnt;
    w_mcStall   = 1'b0;
    case (r_mcState)
      MC_IDLE: begin
        if (iRSTn && hz.iEX_MultiCycle && (MC_LAT > 0)) begin
          w_mcStall   = 1'b1;
          w_mcNext    = MC_BUSY;
          w_mcCntNext = c_MC_W'(1);
        end
      end
      MC_BUSY: begin
        if (r_mcCnt < c_MC_LAST) begin
          w_mcStall   = 1'b1;
          w_mcCntNext = r_mcCnt + 1'b1;
        end else begin
          w_mcNext    = MC_IDLE;
          w_mcCntNext = '0;
        end
      end
      default: w_mcNext = MC_IDLE;
    endcase
  end

  // External unit wait with watchdog: the final counted cycle is released with a pulse.
  always_comb begin
    w_extNext    = r_extState;
    w_extCntNext = r_extCnt;
    w_extStall   = 1'b0;
    w_extTimeout = 1'b0;
    case (r_extState)
      EXT_IDLE: begin
        if (iRSTn && hz.iEX_ExtStart && !hz.iEX_ExtReady) begin
          if (EXT_TIMEOUT <= 1) begin
            w_extTimeout = 1'b1;
          end else begin
            w_extStall   = 1'b1;
            w_extNext    = EXT_WAIT;
            w_extCntNext = c_EXT_W'(1);
          end
        end
      end
      EXT_WAIT: begin
        if (!hz.iEX_ExtStart || hz.iEX_ExtReady) begin
          w_extNext    = EXT_IDLE;
          w_extCntNext = '0;
        end else if (r_extCnt == c_EXT_LAST) begin
          w_extTimeout = 1'b1;
          w_extNext    = EXT_IDLE;
          w_extCntNext = '0;
        end else begin
          w_extStall   = 1'b1;
          w_extCntNext = r_extCnt + 1'b1;
        end
      end
      default: w_extNext = EXT_IDLE;
    endcase
  end

  // Stall/flush priority: long-latency freeze, then load-use bubble, then redirect.
  always_comb begin
    w_stall = 5'b00000;
    w_flush = 4'b0000;
    if (w_mcStall || w_extStall) begin
      w_stall = 5'b11111;
    end else if (w_luHit) begin
      w_stall = 5'b00001;
      w_flush = 4'b0010;
    end else if (hz.iID_Redirect) begin
      w_flush = 4'b0001;
    end
  end

  // Saturating count of IF-hold cycles; clear takes precedence over increment.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn)
      r_stallCycles <= '0;
    else if (hz.iClrCnt)
      r_stallCycles <= '0;
    else if (w_stall[0] && (r_stallCycles != {CNT_W{1'b1}}))
      r_stallCycles <= r_stallCycles + 1'b1;
  end

  assign hz.oStall       = w_stall;
  assign hz.oFlush       = w_flush;
  assign hz.oFwdID       = w_fwdId;
  assign hz.oFwdEX       = w_fwdEx;
  assign hz.oExtTimeout  = w_extTimeout;
  assign hz.oStallCycles = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit_param
// Brief    : Directed bench for fwd_hazard_unit_param with a cycle-level
//            reference model checked every cycle, plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit_param;
  localparam int REG_W       = 5;
  localparam int NSRC        = 2;
  localparam int MC_LAT      = 6;
  localparam int EXT_TIMEOUT = 64;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   nRun  = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_param_if #(.REG_W(REG_W), .NSRC(NSRC), .CNT_W(CNT_W)) bus ();

  fwd_hazard_unit_param #(
    .REG_W(REG_W), .NSRC(NSRC), .MC_LAT(MC_LAT),
    .EXT_TIMEOUT(EXT_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .iCLK (clk),
    .iRSTn(rstn),
    .hz   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Reference forwarding: scan producers nearest-first (0=EX,1=MEM,2=WB).
  function automatic logic [2:0] modelFwd(input logic [REG_W-1:0] rs, input logic used,
                                          input int firstStage);
    logic [REG_W-1:0] rd [3];
    logic [1:0]       ws [3];
    logic [2:0]       code;
    logic             found;
    rd[0] = bus.iEX_Rd;    rd[1] = bus.iMEM_Rd;    rd[2] = bus.iWB_Rd;
    ws[0] = bus.iEX_WrSrc; ws[1] = bus.iMEM_WrSrc; ws[2] = bus.iWB_WrSrc;
    code  = 3'b000;
    found = 1'b0;
    for (int s = firstStage; s < 3; s++) begin
      if (!found && used && rd[s] != '0 && ws[s] != 2'd0 && rd[s] == rs) begin
        found = 1'b1;
        if (s == 2)            code = 3'b011;
        else if (ws[s] == 2'd3) code = 3'b000;
        else if (s == 0)       code = (ws[s] == 2'd1) ? 3'b001 : 3'b101;
        else                   code = (ws[s] == 2'd1) ? 3'b010 : 3'b110;
      end
    end
    return code;
  endfunction

  function automatic logic loadHit(input logic [REG_W-1:0] rd, input logic [1:0] ws,
                                   input logic [REG_W-1:0] rs, input logic used);
    return used && rd != '0 && ws == 2'd3 && rd == rs;
  endfunction

  // Model state: stall cycles already spent on the current DIV, a pending
  // release cycle, cycles spent waiting on the external unit, expected count.
  int mcDone, extWaited, expCnt;
  bit mcRel;

  initial begin
    logic             mcS, extS, extTo, lu;
    logic [4:0]       eStall;
    logic [3:0]       eFlush;
    logic [NSRC*3-1:0] eFwdId, eFwdEx;
    logic [REG_W-1:0] rsI, rsE;
    mcDone = 0; mcRel = 0; extWaited = 0; expCnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mcDone = 0; mcRel = 0; extWaited = 0; expCnt = 0;
      end
      mcS   = rstn && (mcDone > 0 || (!mcRel && bus.iEX_MultiCycle && MC_LAT > 0));
      extS  = 1'b0;
      extTo = 1'b0;
      if (rstn && bus.iEX_ExtStart && !bus.iEX_ExtReady) begin
        if (extWaited == EXT_TIMEOUT - 1) extTo = 1'b1;
        else                              extS  = 1'b1;
      end
      lu = 1'b0;
      eFwdId = '0;
      eFwdEx = '0;
      for (int k = 0; k < NSRC; k++) begin
        rsI = bus.iID_Rs[k*REG_W +: REG_W];
        rsE = bus.iEX_Rs[k*REG_W +: REG_W];
        eFwdId[k*3 +: 3] = modelFwd(rsI, bus.iID_RsUsed[k], 0);
        eFwdEx[k*3 +: 3] = modelFwd(rsE, bus.iEX_RsUsed[k], 1);
        if (loadHit(bus.iEX_Rd, bus.iEX_WrSrc, rsI, bus.iID_RsUsed[k])) lu = 1'b1;
        if (bus.iID_UsesInID && loadHit(bus.iMEM_Rd, bus.iMEM_WrSrc, rsI, bus.iID_RsUsed[k]))
          lu = 1'b1;
      end
      if (mcS || extS) begin
        eStall = 5'b11111; eFlush = 4'b0000;
      end else if (lu) begin
        eStall = 5'b00001; eFlush = 4'b0010;
      end else if (bus.iID_Redirect) begin
        eStall = 5'b00000; eFlush = 4'b0001;
      end else begin
        eStall = 5'b00000; eFlush = 4'b0000;
      end

      check("m_stall",   32'(bus.oStall),       32'(eStall));
      check("m_flush",   32'(bus.oFlush),       32'(eFlush));
      check("m_fwdid",   32'(bus.oFwdID),       32'(eFwdId));
      check("m_fwdex",   32'(bus.oFwdEX),       32'(eFwdEx));
      check("m_timeout", 32'(bus.oExtTimeout),  32'(extTo));
      check("m_count",   32'(bus.oStallCycles), 32'(expCnt));

      if (rstn) begin
        if (mcRel) mcRel = 0;
        else if (mcS) begin
          mcDone++;
          if (mcDone == MC_LAT) begin
            mcDone = 0;
            mcRel  = 1;
          end
        end
        if (extS) extWaited++;
        else      extWaited = 0;
        if (bus.iClrCnt)                       expCnt = 0;
        else if (eStall[0] && expCnt < CNT_MAX) expCnt++;
      end
    end
  end

  task automatic idle();
    bus.iID_Rs = '0;        bus.iID_RsUsed = '0;   bus.iID_UsesInID = 1'b0;
    bus.iID_Redirect = 1'b0; bus.iEX_Rs = '0;      bus.iEX_RsUsed = '0;
    bus.iEX_Rd = '0;        bus.iMEM_Rd = '0;      bus.iWB_Rd = '0;
    bus.iEX_WrSrc = 2'd0;   bus.iMEM_WrSrc = 2'd0; bus.iWB_WrSrc = 2'd0;
    bus.iEX_MultiCycle = 1'b0; bus.iEX_ExtStart = 1'b0; bus.iEX_ExtReady = 1'b0;
    bus.iClrCnt = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall",   32'(bus.oStall),       32'd0);
    check("rst_flush",   32'(bus.oFlush),       32'd0);
    check("rst_count",   32'(bus.oStallCycles), 32'd0);
    check("rst_timeout", 32'(bus.oExtTimeout),  32'd0);
    nextCycle();
    rstn = 1'b1;

    // ID branch reads x5 produced by ALU in EX
    bus.iEX_Rd = 5'd5; bus.iEX_WrSrc = 2'd1;
    bus.iID_Rs = {5'd0, 5'd5}; bus.iID_RsUsed = 2'b01; bus.iID_UsesInID = 1'b1;
    @(negedge clk);
    check("t1_fwdid", 32'(bus.oFwdID[2:0]), 32'b001);
    check("t1_stall", 32'(bus.oStall), 32'd0);
    nextCycle(); bus.iEX_WrSrc = 2'd2;
    @(negedge clk); check("t1_pc4", 32'(bus.oFwdID[2:0]), 32'b101);
    nextCycle(); bus.iEX_WrSrc = 2'd1; bus.iMEM_Rd = 5'd5; bus.iMEM_WrSrc = 2'd1;
    bus.iID_Rs = {5'd5, 5'd5}; bus.iID_RsUsed = 2'b11;
    @(negedge clk); check("t1_exwins", 32'(bus.oFwdID), 32'b001_001);
    nextCycle(); bus.iEX_Rd = 5'd0;
    @(negedge clk); check("t1_mem", 32'(bus.oFwdID), 32'b010_010);
    nextCycle(); idle(); bus.iWB_Rd = 5'd5; bus.iWB_WrSrc = 2'd3;
    bus.iID_Rs = {5'd0, 5'd5}; bus.iID_RsUsed = 2'b01;
    @(negedge clk); check("t1_wb", 32'(bus.oFwdID[2:0]), 32'b011);
    nextCycle(); idle(); bus.iEX_Rd = 5'd0; bus.iEX_WrSrc = 2'd3; bus.iID_RsUsed = 2'b01;
    @(negedge clk);
    check("x0_fwd",   32'(bus.oFwdID), 32'd0);
    check("x0_stall", 32'(bus.oStall), 32'd0);

    // EX-stage forwarding for operand 1
    nextCycle(); idle(); bus.iEX_Rs = {5'd9, 5'd0}; bus.iEX_RsUsed = 2'b10;
    bus.iMEM_Rd = 5'd9; bus.iMEM_WrSrc = 2'd1; bus.iWB_Rd = 5'd9; bus.iWB_WrSrc = 2'd1;
    @(negedge clk); check("ex_mem_alu", 32'(bus.oFwdEX[5:3]), 32'b010);
    nextCycle(); bus.iMEM_WrSrc = 2'd2;
    @(negedge clk); check("ex_mem_pc4", 32'(bus.oFwdEX[5:3]), 32'b110);
    nextCycle(); bus.iMEM_WrSrc = 2'd3;
    @(negedge clk); check("ex_mem_load", 32'(bus.oFwdEX[5:3]), 32'b000);
    nextCycle(); bus.iMEM_Rd = 5'd0;
    @(negedge clk); check("ex_wb", 32'(bus.oFwdEX[5:3]), 32'b011);
    nextCycle(); bus.iEX_RsUsed = 2'b01;
    @(negedge clk); check("ex_unused", 32'(bus.oFwdEX), 32'd0);

    // Load-use: load x7 in EX, add reads x7 in ID
    nextCycle(); idle(); bus.iEX_Rd = 5'd7; bus.iEX_WrSrc = 2'd3;
    bus.iID_Rs = {5'd7, 5'd0}; bus.iID_RsUsed = 2'b10;
    @(negedge clk);
    check("t2_stall", 32'(bus.oStall), 32'b00001);
    check("t2_flush", 32'(bus.oFlush), 32'b0010);
    nextCycle(); bus.iEX_Rd = 5'd0; bus.iEX_WrSrc = 2'd0; bus.iMEM_Rd = 5'd7; bus.iMEM_WrSrc = 2'd3;
    @(negedge clk); check("t2_bubble", 32'(bus.oStall), 32'd0);
    nextCycle(); idle(); bus.iWB_Rd = 5'd7; bus.iWB_WrSrc = 2'd3;
    bus.iEX_Rs = {5'd7, 5'd0}; bus.iEX_RsUsed = 2'b10;
    @(negedge clk); check("t2_fwdex", 32'(bus.oFwdEX[5:3]), 32'b011);
    nextCycle(); idle(); bus.iMEM_Rd = 5'd4; bus.iMEM_WrSrc = 2'd3;
    bus.iID_Rs = {5'd0, 5'd4}; bus.iID_RsUsed = 2'b01; bus.iID_UsesInID = 1'b1;
    @(negedge clk); check("br_memload", 32'(bus.oStall), 32'b00001);

    // Load-use together with redirect
    nextCycle(); idle(); bus.iEX_Rd = 5'd3; bus.iEX_WrSrc = 2'd3;
    bus.iID_Rs = {5'd0, 5'd3}; bus.iID_RsUsed = 2'b01; bus.iID_Redirect = 1'b1;
    @(negedge clk);
    check("t5_stall", 32'(bus.oStall), 32'b00001);
    check("t5_flush", 32'(bus.oFlush), 32'b0010);
    nextCycle(); bus.iEX_Rd = 5'd0; bus.iEX_WrSrc = 2'd0;
    @(negedge clk); check("t5_redirect", 32'(bus.oFlush), 32'b0001);

    // Two back-to-back DIVs
    nextCycle(); idle(); bus.iEX_MultiCycle = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("t3_div", 32'(bus.oStall), (i == 6 || i == 13) ? 32'd0 : 32'h1f);
    end
    nextCycle(); idle(); bus.iClrCnt = 1'b1;

    // Watchdog: external unit never answers
    nextCycle(); bus.iClrCnt = 1'b0; bus.iEX_ExtStart = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) check("clr_count", 32'(bus.oStallCycles), 32'd0);
      check("t4_stall",   32'(bus.oStall),      (i < 63) ? 32'h1f : 32'd0);
      check("t4_timeout", 32'(bus.oExtTimeout), (i == 63) ? 32'd1 : 32'd0);
    end
    nextCycle(); idle();
    @(negedge clk); check("cnt_full", 32'(bus.oStallCycles), 32'd63);
    nextCycle(); bus.iEX_Rd = 5'd2; bus.iEX_WrSrc = 2'd3;
    bus.iID_Rs = {5'd0, 5'd2}; bus.iID_RsUsed = 2'b01;
    nextCycle(); idle();
    @(negedge clk); check("cnt_sat", 32'(bus.oStallCycles), 32'd63);

    // External unit answers after two cycles
    nextCycle(); bus.iEX_ExtStart = 1'b1;
    @(negedge clk); check("ext_w0", 32'(bus.oStall), 32'h1f);
    nextCycle();
    @(negedge clk); check("ext_w1", 32'(bus.oStall), 32'h1f);
    nextCycle(); bus.iEX_ExtReady = 1'b1;
    @(negedge clk);
    check("ext_rdy_stall", 32'(bus.oStall), 32'd0);
    check("ext_rdy_to",    32'(bus.oExtTimeout), 32'd0);

    // Reset in the middle of a DIV, then the DIV starts over
    nextCycle(); idle(); bus.iEX_MultiCycle = 1'b1;
    @(negedge clk); check("t6_c1", 32'(bus.oStall), 32'h1f);
    @(negedge clk); check("t6_c2", 32'(bus.oStall), 32'h1f);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_stall", 32'(bus.oStall), 32'd0);
    check("t6_rst_count", 32'(bus.oStallCycles), 32'd0);
    nextCycle(); rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t6_restart", 32'(bus.oStall), (i == 6) ? 32'd0 : 32'h1f);
    end
    nextCycle(); idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule
`default_nettype wire
